// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a byte FIFO of 2**DEPTH_LOG2 entries.
// o_tx follows the FSM state one cycle late; each bit still lasts CLKS_PER_BIT cycles.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  i_clk25MHz,
  input  logic                  i_reset_n,
  input  logic [7:0]            i_tx_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic [1:0]            o_dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]       BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] FULL      = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Handshake: a byte moves on a rising edge where i_valid and o_ready are both
  // high. o_ready is a register, so it never depends on i_valid in the same cycle.

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ready;

  state_t                r_state;
  logic [BW-1:0]         r_baud;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic                  r_tx;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_baud_done;
  logic [DEPTH_LOG2:0]   w_count_next;

  assign w_push      = i_valid & r_ready;
  assign w_baud_done = (r_baud == BAUD_LAST);
  // Pops happen from IDLE or on the final STOP cycle so frames chain with no gap.
  assign w_pop       = (r_count != '0) &&
                       ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clk25MHz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_tx_data;
    end
  end

  always_ff @(posedge i_clk25MHz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_ready <= (w_count_next < FULL);
    end
  end

  always_ff @(posedge i_clk25MHz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_shift[r_bit_idx];
        default: r_tx <= 1'b1;
      endcase

      case (r_state)
        IDLE: begin
          r_baud    <= '0;
          r_bit_idx <= 3'd0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_tx        = r_tx;
  assign o_count     = r_count;
  assign o_busy      = (r_state != IDLE) || (r_count != '0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a fast instance (4 clocks/bit, depth 4) checked by a
// receiver model against an expected-byte queue, plus a default-parameter instance.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int B_CPB = 217;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0]   tx_data;
  logic         valid;
  logic         ready, tx, busy;
  logic [DL2:0] count;
  logic [1:0]   state;

  logic [7:0]   b_data;
  logic         b_valid;
  logic         b_ready, b_tx, b_busy;
  logic [4:0]   b_count;
  logic [1:0]   b_state;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) u_dut (
    .i_clk25MHz(clk), .i_reset_n(rst_n), .i_tx_data(tx_data), .i_valid(valid),
    .o_ready(ready), .o_tx(tx), .o_busy(busy), .o_count(count), .o_dbg_state(state)
  );

  uart_tx_fifo u_dut_b (
    .i_clk25MHz(clk), .i_reset_n(rst_n), .i_tx_data(b_data), .i_valid(b_valid),
    .o_ready(b_ready), .o_tx(b_tx), .o_busy(b_busy), .o_count(b_count), .o_dbg_state(b_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int starts_q[$];
  int n_frames = 0;
  int ncyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: reference receiver sampling mid-bit on the falling clock edge
  logic       prev_tx = 1'b1;
  bit         in_frame = 1'b0;
  int         pos = 0;
  logic [7:0] rx = 8'd0;

  always @(negedge clk) begin
    ncyc++;
    if (rst_n !== 1'b1) begin
      in_frame = 1'b0;
      prev_tx  = 1'b1;
    end else begin
      if (!in_frame) begin
        if (prev_tx && !tx) begin
          in_frame = 1'b1;
          pos      = 0;
          starts_q.push_back(ncyc);
        end
      end else begin
        pos++;
        if (pos == CPB / 2) begin
          chk("start_bit", tx, 1'b0);
        end else if (pos >= CPB + CPB / 2 && pos < 9 * CPB && ((pos - CPB / 2) % CPB) == 0) begin
          rx[(pos - CPB / 2) / CPB - 1] = tx;
        end else if (pos == 9 * CPB + CPB / 2) begin
          chk("stop_bit", tx, 1'b1);
          if (exp_q.size() == 0) chk("rx_extra_byte", rx, 32'hffff_ffff);
          else chk("rx_byte", rx, exp_q.pop_front());
          n_frames++;
          in_frame = 1'b0;
        end
      end
    end
    prev_tx = tx;
  end

  // driver: called at a falling edge; returns at the falling edge after acceptance
  task automatic push_a(input logic [7:0] b, input bit hold);
    int guard;
    guard   = 0;
    valid   = 1'b1;
    tx_data = b;
    while (!ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      chk("ready_timeout", ready, 1'b1);
      valid = 1'b0;
      return;
    end
    exp_q.push_back(b);
    @(negedge clk);
    if (!hold) valid = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k, fall_k, nf, start_cnt;
    bit low_seen;
    logic [9:0] fb;
    logic sb, bit6, bit7;

    rst_n = 1'b0; valid = 1'b0; tx_data = 8'd0; b_valid = 1'b0; b_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", state, S_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", ready, 1'b1);
    chk("b_ready_after_reset", b_ready, 1'b1);
    repeat (2) @(negedge clk);

    // single byte 0x55: exact line pattern and latency
    fb = {1'b1, 8'h55, 1'b0};
    push_a(8'h55, 1'b0);
    k = 0; fall_k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
      if (fall_k == 0 && !tx) fall_k = k;
      if (k >= 4 && (k % 4) == 0 && k <= 40) chk("line_bit", tx, fb[k / 4 - 1]);
    end
    chk("tx_fall_edge", fall_k, 2);
    chk("busy_low_cycle", k, 41);
    drain_a("single_drained");

    // burst of five with i_valid held high
    starts_q.delete();
    for (int i = 1; i <= 5; i++) push_a(8'(i), (i != 5));
    chk("burst_count_full", count, 4);
    chk("burst_ready_full", ready, 1'b0);
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ready_rise_delay", k, 37);
    chk("count_after_pop", count, 3);
    drain_a("burst_drained");
    chk("burst_frames", starts_q.size(), 5);
    for (int i = 1; i < starts_q.size(); i++)
      chk("burst_gap", starts_q[i] - starts_q[i-1], 10 * CPB);
    if (starts_q.size() == 5)
      chk("burst_span", starts_q[4] + 10 * CPB - starts_q[0], 50 * CPB);

    // push on the same edge as a STOP-end pop with two bytes queued
    push_a(8'h11, 1'b0);
    push_a(8'h22, 1'b0);
    push_a(8'h33, 1'b0);
    chk("pp_count_before", count, 2);
    repeat (10 * CPB - 2) @(negedge clk);
    chk("pp_state_stop", state, S_STOP);
    chk("pp_count_at_pop", count, 2);
    push_a(8'h44, 1'b0);
    chk("pp_count_after", count, 2);
    drain_a("pp_drained");

    // reset during data bit 3 of 0xA5 with three bytes queued
    push_a(8'hA5, 1'b0);
    push_a(8'hB1, 1'b0);
    push_a(8'hB2, 1'b0);
    push_a(8'hB3, 1'b0);
    chk("rst_mid_count", count, 3);
    repeat (15) @(negedge clk);
    chk("rst_mid_state", state, S_DATA);
    chk("rst_mid_line_bit3", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_count0", count, 0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ready", ready, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", ready, 1'b1);
    nf = n_frames; low_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (!tx) low_seen = 1'b1;
    end
    chk("no_restart_line", low_seen, 1'b0);
    chk("no_restart_frames", n_frames, nf);
    push_a(8'h3C, 1'b0);
    drain_a("post_reset_drained");

    // random stream with random gaps; data wiggles while idle
    for (int i = 0; i < 1000; i++) begin
      valid = 1'b0;
      tx_data = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        tx_data = 8'($urandom);
      end
      push_a(8'($urandom_range(0, 255)), 1'b0);
    end
    drain_a("random_drained");
    chk("random_busy_idle", busy, 1'b0);

    // default parameters, byte 0x80
    b_valid = 1'b1; b_data = 8'h80;
    chk("b_ready", b_ready, 1'b1);
    @(negedge clk);
    b_valid = 1'b0;
    b_data = 8'h7F;
    k = 0; fall_k = 0; start_cnt = 0; sb = 1'b1; bit6 = 1'b1; bit7 = 1'b0;
    while (b_busy && k < 3000) begin
      @(negedge clk);
      k++;
      if (fall_k == 0 && !b_tx) fall_k = k;
      if (b_state == S_START) start_cnt++;
      if (k == 2 + B_CPB / 2) sb = b_tx;
      if (k == 2 + 7 * B_CPB + B_CPB / 2) bit6 = b_tx;
      if (k == 2 + 8 * B_CPB + B_CPB / 2) bit7 = b_tx;
    end
    chk("b_tx_fall_edge", fall_k, 2);
    chk("b_start_len", start_cnt, B_CPB);
    chk("b_start_bit", sb, 1'b0);
    chk("b_bit6", bit6, 1'b0);
    chk("b_bit7", bit7, 1'b1);
    chk("b_frame_len", k - 1, 10 * B_CPB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, clock cycles per serial bit (25 MHz / 115200 baud).
REQ-002 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-003 i_clk25MHz  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset_n  input  1  reset; asynchronous and active-low.
REQ-005 i_tx_data  input  8  byte offered for transmission.
REQ-006 i_valid  input  1  i_tx_data is valid this cycle.
REQ-007 o_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 o_tx  output  1  serial line, 8N1, idle high.
REQ-009 o_busy  output  1  a frame is in progress or the FIFO is non-empty.
REQ-010 o_count  output  DEPTH_LOG2+1  bytes currently held in the FIFO, excluding the byte being shifted.

Function
REQ-011 A byte SHALL be accepted on a rising edge where i_valid and o_ready are both high; no other edge writes the FIFO.
REQ-012 o_ready SHALL be high exactly when o_count < 2**DEPTH_LOG2, registered, with no combinational path from i_valid.
REQ-013 FIFO order SHALL be first-in first-out; read and write pointers are DEPTH_LOG2 bits and wrap from 2**DEPTH_LOG2-1 to 0.
REQ-014 Transmit FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: o_tx=1; when o_count>0, pop head byte into the shift register and go to START on the same edge.
REQ-016 START: o_tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; after bit 7 go to STOP.
REQ-018 STOP: o_tx=1 for CLKS_PER_BIT cycles; on its last cycle pop and go directly to START if o_count>0, otherwise go to IDLE.
REQ-019 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL have zero idle cycles between stop and next start bit.
REQ-020 Latency: with FSM IDLE and FIFO empty, o_tx SHALL fall on the second rising edge after the accepting edge.
REQ-021 o_tx SHALL be driven from a register (glitch-free).
REQ-022 Simultaneous push and pop on one edge SHALL leave o_count unchanged and both bytes correctly ordered.
REQ-023 Push when full is impossible (o_ready low); a pop on a full cycle raises o_ready on the following cycle.
REQ-024 i_tx_data and i_valid changes during a frame SHALL not affect the frame in progress.
REQ-025 o_busy SHALL be low only in IDLE with o_count=0.

Reset
REQ-026 Assertion of i_reset_n low SHALL immediately force: FSM IDLE, o_tx=1, o_count=0, pointers 0, bit/baud counters 0, o_busy=0, o_ready=0.
REQ-027 o_ready SHALL go high on the first rising edge after i_reset_n deasserts.
REQ-028 Reset mid-frame SHALL abort the frame, return o_tx high at once, and discard all FIFO contents; no partial frame resumes after release.

Verification (CLKS_PER_BIT=4, DEPTH_LOG2=2 unless noted)
REQ-029 Single byte 0x55 pushed after reset -> o_tx low 2 edges after accept; line pattern 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit; o_busy low 40 cycles after start edge.
REQ-030 Burst of 0x01,0x02,0x03,0x04,0x05 with i_valid held high -> o_ready low when o_count=4; all five bytes sent in order with no idle gap; total 50 bit-times from first start bit.
REQ-031 Push on the same edge as a pop with o_count=2 -> o_count stays 2; output byte sequence unchanged in order.
REQ-032 i_reset_n pulsed low during DATA bit 3 of 0xA5 with 3 bytes queued -> o_tx=1 and o_count=0 immediately; no further start bit after release until a new push.
REQ-033 Default parameters, byte 0x80 -> start bit 217 cycles, bit 7 high, total frame 2170 cycles.
REQ-034 Random 1000-byte stream with random i_valid gaps, checked by a reference UART receiver model -> zero byte errors, zero framing errors, no accepted byte lost or duplicated.
